sd_cmd_arbiter: RTL and testbench
=================================

// Module: sd_cmd_arbiter
// PURPOSE
//  Shares one SD command/response engine (index/argument/start -> busy/finish/response/DI)
//  between two requesters: port 0 = card init sequencer, port 1 = block read/write controller.
//  Grants the engine round-robin, latches command fields at grant, sequences the start/finish
//  handshake, muxes the engine's DI onto the card line, and returns the 40-bit response.
// PARAMETERS
//  TIMEOUT_CYCLES  200000  clk cycles allowed from start to engine finish (SD_ARB_TIMEOUT_EN only)
//  CNT_W           18      width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk           in   1   system clock; all logic and eng_* handshake are synchronous to it
//  rst           in   1   asynchronous reset, active-high
//  req0/req1     in   1   request; hold high until matching done pulse
//  idx0/idx1     in   6   command index, sampled on grant
//  arg0/arg1     in   32  command argument, sampled on grant
//  gnt0/gnt1     out  1   high from grant cycle through done cycle (one-hot, never both)
//  done0/done1   out  1   one-cycle completion pulse to the granted requester
//  resp          out  40  response of last completed command; valid from done pulse until next done
//  err           out  1   valid with done: 1 = timeout abort, 0 = normal finish
//  eng_index     out  6   to engine
//  eng_argument  out  32  to engine
//  eng_start     out  1   to engine; level, held until finish seen
//  eng_busy      in   1   from engine
//  eng_finish    in   1   from engine; level, high until start drops
//  eng_response  in   40  from engine
//  eng_di        in   1   engine serial data
//  DI            out  1   card DI line; 1 when no command active, else eng_di
// BEHAVIOUR
//  Reset (any time, incl. mid-command): state=IDLE, gnt*=0, done*=0, eng_start=0, DI=1,
//   err=0, resp=0, eng_index=0, eng_argument=0, last-grant pointer=1 (port 0 wins first tie).
//  FSM: IDLE -> WAIT_RDY -> ISSUE -> RUN -> RELEASE -> DONE -> IDLE.
//  IDLE: if any req, grant; both high -> port not granted last wins; single req -> that port.
//   Grant cycle: gnt set, idx/arg latched to eng_index/eng_argument, pointer updated.
//  WAIT_RDY: stay while eng_busy=1; else -> ISSUE.
//  ISSUE: eng_start<=1, timeout counter cleared -> RUN (1 cycle).
//  RUN: DI=eng_di; eng_finish=1 -> resp<=eng_response, err<=0, eng_start<=0 -> RELEASE.
//  RELEASE: DI=1; wait eng_finish=0 -> DONE.
//  DONE: done pulse 1 cycle to granted port, gnt dropped same cycle end -> IDLE.
//  Latency: req (engine idle) to eng_start = 3 cycles; finish to done = 2 cycles min.
//  No back-to-back grant in DONE; new grant earliest the cycle after DONE.
//  Requester dropping req mid-command: command still completes, done still pulses (no SD abort).
//  idx/arg changes after grant ignored. req of non-granted port held pending, never lost.
//  eng_finish seen in WAIT_RDY/ISSUE ignored (stale from previous command).
// CONFIGURATION
//  SD_ARB_TIMEOUT_EN defined: in RUN counter increments each cycle; when it reaches
//   TIMEOUT_CYCLES with no finish -> eng_start<=0, resp<=40'hFFFFFFFFFF, err<=1 -> RELEASE
//   (RELEASE still waits eng_finish=0). Counter saturates, never wraps.
//  Not defined: no counter; RUN waits for eng_finish indefinitely; err constant 0.
// TESTING
//  1 req0 only, idx0=0 arg0=0, engine finishes after 50 cycles with 40'h01 -> gnt0, eng_start
//    3 cycles after req0, done0 pulse, resp=40'h0000000001, err=0, gnt1 never high.
//  2 req0&req1 same cycle after reset, idx0=8 idx1=17 -> port 0 served first, then port 1;
//    repeat both -> port 1 served first (round-robin alternates).
//  3 eng_busy held 1 for 20 cycles at grant -> eng_start stays 0 until busy drops; DI=1 meanwhile.
//  4 req1 dropped mid-RUN -> command completes, done1 still pulses, next req0 granted normally.
//  5 rst pulsed while in RUN -> eng_start=0, DI=1, gnt*=0 immediately (async); fresh req works.
//  6 SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, engine never finishes -> at cycle 100 eng_start=0,
//    done pulse with err=1, resp=40'hFFFFFFFFFF.

Source files
------------

// File: rtl/sd_cmd_arbiter.sv
// rtl/sd_cmd_arbiter.sv - round-robin sharing of one SD command engine between two requesters
// Optional engine timeout abort: define SD_ARB_TIMEOUT_EN.
module sd_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  idx0,
  input  logic [5:0]  idx1,
  input  logic [31:0] arg0,
  input  logic [31:0] arg1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [39:0] resp,
  output logic        err,
  output logic [5:0]  eng_index,
  output logic [31:0] eng_argument,
  output logic        eng_start,
  input  logic        eng_busy,
  input  logic        eng_finish,
  input  logic [39:0] eng_response,
  input  logic        eng_di,
  output logic        DI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_RUN,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t state;
  logic   last;
  logic   sel;

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`else
  localparam int unused_timeout_cfg = TIMEOUT_CYCLES + CNT_W;
`endif

  // On a tie the port that did not win last time gets the engine.
  assign sel = (req0 && req1) ? ~last : req1;

  assign DI = (state == S_RUN) ? eng_di : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last         <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      resp         <= '0;
      err          <= 1'b0;
      eng_index    <= '0;
      eng_argument <= '0;
      eng_start    <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt0         <= ~sel;
            gnt1         <= sel;
            last         <= sel;
            eng_index    <= sel ? idx1 : idx0;
            eng_argument <= sel ? arg1 : arg0;
            state        <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (!eng_busy) state <= S_ISSUE;
        end
        S_ISSUE: begin
          eng_start <= 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
          cnt       <= '0;
`endif
          state     <= S_RUN;
        end
        S_RUN: begin
          if (eng_finish) begin
            resp      <= eng_response;
            err       <= 1'b0;
            eng_start <= 1'b0;
            state     <= S_RELEASE;
          end
`ifdef SD_ARB_TIMEOUT_EN
          // The counter stops at the limit because RUN is left on that same edge.
          else if (cnt >= TO_LAST) begin
            resp      <= 40'hFF_FFFF_FFFF;
            err       <= 1'b1;
            eng_start <= 1'b0;
            state     <= S_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (!eng_finish) begin
            done0 <= gnt0;
            done1 <= gnt1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb/tb_sd_cmd_arbiter.sv - randomized scoreboard bench for sd_cmd_arbiter
// Engine behaviour is modelled here; define SD_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_sd_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [5:0]  idx0 = '0, idx1 = '0;
  logic [31:0] arg0 = '0, arg1 = '0;
  logic        gnt0, gnt1, done0, done1, err, eng_start, DI;
  logic [39:0] resp;
  logic [5:0]  eng_index;
  logic [31:0] eng_argument;
  logic        eng_busy = 1'b0, eng_finish = 1'b0, eng_di = 1'b1;
  logic [39:0] eng_response = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [39:0] resp;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  bit   saw_gnt1 = 1'b0;
  int   last_served = 1;

  int          eng_delay = 5;
  bit          eng_rand = 1'b0, eng_never = 1'b0, eng_ovr_en = 1'b0;
  logic [39:0] eng_ovr = '0;
  int          busy_left = 0;
  bit          eng_running = 1'b0;
  int          eng_cnt = 0, eng_target = 0;

  sd_cmd_arbiter #(.TIMEOUT_CYCLES(100), .CNT_W(18)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .idx0(idx0), .idx1(idx1), .arg0(arg0), .arg1(arg1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .resp(resp), .err(err),
    .eng_index(eng_index), .eng_argument(eng_argument), .eng_start(eng_start),
    .eng_busy(eng_busy), .eng_finish(eng_finish), .eng_response(eng_response),
    .eng_di(eng_di), .DI(DI)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] rsp_of(input logic [5:0] i, input logic [31:0] a);
    return {i, a ^ 32'hA5A5_0F0F, 2'b10};
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Engine: finishes a configurable number of cycles after start, holds finish until start drops.
  initial begin : engine
    forever begin
      @(posedge clk); #1;
      eng_di = 1'($urandom_range(0, 1));
      if (rst) begin
        eng_busy = 1'b0; eng_finish = 1'b0; eng_running = 1'b0; busy_left = 0;
      end else begin
        eng_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (eng_start && !eng_finish) begin
          if (!eng_running) begin
            eng_running = 1'b1;
            eng_cnt = 0;
            eng_target = eng_rand ? int'($urandom_range(0, 8)) : eng_delay;
          end else begin
            eng_cnt++;
          end
          if (!eng_never && eng_cnt >= eng_target) begin
            eng_finish = 1'b1;
            eng_response = eng_ovr_en ? eng_ovr : rsp_of(eng_index, eng_argument);
          end
        end else if (!eng_start) begin
          if (eng_finish && eng_rand) busy_left = int'($urandom_range(0, 3));
          eng_finish = 1'b0;
          eng_running = 1'b0;
        end
      end
    end
  end

  // Monitor: arbitration rule, latched fields, DI routing, and scoreboard pops on done.
  logic pr0 = 1'b0, pr1 = 1'b0, pg0 = 1'b0, pg1 = 1'b0, pst = 1'b0;
  exp_t mon_e;
  int   mon_g, mon_x;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        pr0 = 1'b0; pr1 = 1'b0; pg0 = 1'b0; pg1 = 1'b0; pst = 1'b0; last_served = 1;
      end else begin
        check(DI === (eng_start ? eng_di : 1'b1), "di_route", DI, eng_start ? eng_di : 1'b1);
        check(!(gnt0 && gnt1), "gnt_onehot", {gnt0, gnt1}, 0);
        if (gnt1) saw_gnt1 = 1'b1;
        if ((gnt0 || gnt1) && !pg0 && !pg1) begin
          mon_g = gnt1 ? 1 : 0;
          check(pr0 || pr1, "grant_without_req", {pr0, pr1}, 1);
          mon_x = (pr0 && pr1) ? ((last_served == 1) ? 0 : 1) : (pr1 ? 1 : 0);
          check(mon_g == mon_x, "rr_grant", mon_g, mon_x);
          last_served = mon_g;
          grant_log.push_back(mon_g);
        end
        if (eng_start && !pst) begin
          if (gnt1) begin
            if (q1.size() == 0) check(1'b0, "start_no_cmd1", 1, 0);
            else check({eng_index, eng_argument} == {q1[0].idx, q1[0].arg}, "cmd_fields1",
                       {eng_index, eng_argument}, {q1[0].idx, q1[0].arg});
          end else begin
            if (q0.size() == 0) check(1'b0, "start_no_cmd0", 1, 0);
            else check({eng_index, eng_argument} == {q0[0].idx, q0[0].arg}, "cmd_fields0",
                       {eng_index, eng_argument}, {q0[0].idx, q0[0].arg});
          end
        end
        if (done0) begin
          check(gnt0 && !done1, "done0_with_gnt0", {gnt0, done1}, 2'b10);
          if (q0.size() == 0) check(1'b0, "done0_unexpected", 1, 0);
          else begin
            mon_e = q0.pop_front();
            check(resp === mon_e.resp, "resp0", resp, mon_e.resp);
            check(err === mon_e.err, "err0", err, mon_e.err);
          end
        end
        if (done1) begin
          check(gnt1 && !done0, "done1_with_gnt1", {gnt1, done0}, 2'b10);
          if (q1.size() == 0) check(1'b0, "done1_unexpected", 1, 0);
          else begin
            mon_e = q1.pop_front();
            check(resp === mon_e.resp, "resp1", resp, mon_e.resp);
            check(err === mon_e.err, "err1", err, mon_e.err);
          end
        end
        pr0 = req0; pr1 = req1; pg0 = gnt0; pg1 = gnt1; pst = eng_start;
      end
    end
  end

  task automatic req_cmd(input int p, input logic [5:0] i, input logic [31:0] a,
                         input logic [39:0] er, input logic ee, input bit drop_on_start);
    exp_t e;
    bit   got;
    e.idx = i; e.arg = a; e.resp = er; e.err = ee;
    @(posedge clk); #1;
    if (p == 0) begin idx0 = i; arg0 = a; req0 = 1'b1; q0.push_back(e); end
    else        begin idx1 = i; arg1 = a; req1 = 1'b1; q1.push_back(e); end
    got = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin got = 1'b1; break; end
    end
    check(got, $sformatf("grant_wait%0d", p), got, 1);
    @(posedge clk); #1;
    if (p == 0) begin idx0 = 6'($urandom); arg0 = $urandom; end
    else        begin idx1 = 6'($urandom); arg1 = $urandom; end
    if (drop_on_start) begin
      got = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        @(negedge clk);
        if (eng_start) begin got = 1'b1; break; end
      end
      check(got, $sformatf("start_wait%0d", p), got, 1);
      @(posedge clk); #1;
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    got = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ((p == 0) ? done0 : done1) begin got = 1'b1; break; end
    end
    check(got, $sformatf("done_wait%0d", p), got, 1);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_cmd(input int p);
    logic [5:0]  i;
    logic [31:0] a;
    i = 6'($urandom);
    a = $urandom;
    req_cmd(p, i, a, rsp_of(i, a), 1'b0, ($urandom_range(0, 3) == 0));
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    rst = 1'b0;
    q0.delete(); q1.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    bit bad;
    bit got;
    int hi;
    repeat (3) @(negedge clk);
    #1;
    check(gnt0 === 1'b0 && gnt1 === 1'b0, "rst_gnt", {gnt0, gnt1}, 0);
    check(done0 === 1'b0 && done1 === 1'b0, "rst_done", {done0, done1}, 0);
    check(eng_start === 1'b0, "rst_start", eng_start, 0);
    check(DI === 1'b1, "rst_di", DI, 1);
    check(err === 1'b0, "rst_err", err, 0);
    check(resp === 40'h0, "rst_resp", resp, 0);
    check(eng_index === 6'h0 && eng_argument === 32'h0, "rst_fields", {eng_index, eng_argument}, 0);
    #1 rst = 1'b0;

    // Single port 0 request, 3-cycle request-to-start latency.
    saw_gnt1 = 1'b0; eng_ovr_en = 1'b1; eng_ovr = 40'h1; eng_delay = 50;
    fork
      req_cmd(0, 6'd0, 32'd0, 40'h00_0000_0001, 1'b0, 1'b0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        check(gnt0 === 1'b0 && eng_start === 1'b0, "lat_k0", {gnt0, eng_start}, 0);
        @(negedge clk);
        check(gnt0 === 1'b1, "lat_gnt_k1", gnt0, 1);
        @(negedge clk);
        check(eng_start === 1'b0, "lat_start_k2", eng_start, 0);
        @(negedge clk);
        check(eng_start === 1'b1, "lat_start_k3", eng_start, 1);
      end
    join
    eng_ovr_en = 1'b0;
    check(!saw_gnt1, "gnt1_never", saw_gnt1, 0);

    // Ties alternate: after reset port 0 wins, after a port-0-only command port 1 wins.
    do_reset();
    eng_delay = 4;
    grant_log.delete();
    fork
      req_cmd(0, 6'd8,  32'h0000_0808, rsp_of(6'd8,  32'h0000_0808), 1'b0, 1'b0);
      req_cmd(1, 6'd17, 32'h0000_1717, rsp_of(6'd17, 32'h0000_1717), 1'b0, 1'b0);
    join
    check(grant_log.size() == 2 && grant_log[0] == 0 && grant_log[1] == 1, "rr_order_a",
          {grant_log.size() == 2, 1'(grant_log[0]), 1'(grant_log[1])}, 3'b101);
    req_cmd(0, 6'd2, 32'hCAFE_0002, rsp_of(6'd2, 32'hCAFE_0002), 1'b0, 1'b0);
    grant_log.delete();
    fork
      req_cmd(0, 6'd8,  32'h1111_0008, rsp_of(6'd8,  32'h1111_0008), 1'b0, 1'b0);
      req_cmd(1, 6'd17, 32'h2222_0017, rsp_of(6'd17, 32'h2222_0017), 1'b0, 1'b0);
    join
    check(grant_log.size() == 2 && grant_log[0] == 1 && grant_log[1] == 0, "rr_order_b",
          {grant_log.size() == 2, 1'(grant_log[0]), 1'(grant_log[1])}, 3'b110);

    // Engine busy at grant holds off start.
    eng_delay = 3;
    busy_left = 24;
    repeat (2) @(posedge clk);
    fork
      req_cmd(1, 6'd33, 32'h0BAD_BEEF, rsp_of(6'd33, 32'h0BAD_BEEF), 1'b0, 1'b0);
      begin
        bad = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (eng_start !== 1'b0 || DI !== 1'b1) bad = 1'b1;
        end
        check(!bad, "busy_holds_start", bad, 0);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (eng_start) begin got = 1'b1; break; end
        end
        check(got, "start_after_busy", got, 1);
      end
    join

    // Requester drops mid-RUN; command still completes, next request served.
    eng_delay = 30;
    req_cmd(1, 6'd44, 32'h4444_0044, rsp_of(6'd44, 32'h4444_0044), 1'b0, 1'b1);
    eng_delay = 2;
    req_cmd(0, 6'd45, 32'h4545_0045, rsp_of(6'd45, 32'h4545_0045), 1'b0, 1'b0);

    // Asynchronous reset in RUN.
    eng_delay = 1000;
    @(posedge clk); #1;
    idx0 = 6'd50; arg0 = 32'h5050_5050; req0 = 1'b1;
    q0.push_back({6'd50, 32'h5050_5050, rsp_of(6'd50, 32'h5050_5050), 1'b0});
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (eng_start) begin got = 1'b1; break; end
    end
    check(got, "rst_run_reached", got, 1);
    #2 rst = 1'b1;
    #1;
    check(eng_start === 1'b0 && DI === 1'b1, "async_rst_start_di", {eng_start, DI}, 2'b01);
    check(gnt0 === 1'b0 && gnt1 === 1'b0, "async_rst_gnt", {gnt0, gnt1}, 0);
    req0 = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    eng_delay = 4;
    req_cmd(1, 6'd51, 32'h5151_5151, rsp_of(6'd51, 32'h5151_5151), 1'b0, 1'b0);

    // Random concurrent traffic against the scoreboard.
    eng_rand = 1'b1;
    fork
      for (int n = 0; n < 15; n++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        rand_cmd(0);
      end
      for (int n = 0; n < 15; n++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        rand_cmd(1);
      end
    join
    eng_rand = 1'b0;

`ifdef SD_ARB_TIMEOUT_EN
    // Engine never finishes: abort after exactly 100 cycles of start.
    eng_never = 1'b1;
    fork
      req_cmd(0, 6'd5, 32'h0000_1234, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
      begin
        hi = 0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (eng_start) begin got = 1'b1; break; end
        end
        if (got) begin
          hi = 1;
          for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (eng_start) hi++; else break;
          end
        end
        check(hi == 100, "timeout_start_cycles", hi, 100);
      end
    join
    eng_never = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check(q0.size() == 0, "sb_empty0", q0.size(), 0);
    check(q1.size() == 0, "sb_empty1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
